// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core; owns PC and IR.
// Optional performance counters are enabled by defining SEQ_PERF_CNT_EN.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        dec_rf_wen,
    input  logic        dec_dm_wen,
    input  logic        dec_mem_rd,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        rf_wen,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        halt_req,
    output logic        halted,
    output logic        retire,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= 32'h0000_0013;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!halt_req) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (dec_mem_rd || dec_dm_wen) state <= S_MEM;
                    else                          state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) state <= S_WB;
                end
                S_WB: begin
                    // Branch targets are forced word-aligned; sequential PC wraps mod 2^32.
                    pc    <= branch_taken ? (branch_target & 32'hFFFF_FFFC) : pc + 32'd4;
                    state <= halt_req ? S_IDLE : S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore decode from the state register, so reset clears every request at once.
    assign halted    = (state == S_IDLE);
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = (state == S_MEM) && dec_dm_wen;
    assign rf_wen    = (state == S_WB) && dec_rf_wen;
    assign retire    = (state == S_WB);

`ifdef SEQ_PERF_CNT_EN
    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (state == S_WB) instret_q <= instret_q + 64'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: a per-instruction timeline model predicts every output each cycle.
module tb_core_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        dec_rf_wen = 1'b0;
    logic        dec_dm_wen = 1'b0;
    logic        dec_mem_rd = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        rf_wen;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready = 1'b0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        retire;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    core_sequencer #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc),
        .dec_rf_wen(dec_rf_wen), .dec_dm_wen(dec_dm_wen), .dec_mem_rd(dec_mem_rd),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .rf_wen(rf_wen), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .halted(halted), .retire(retire),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    // One record per clock cycle: inputs to apply and outputs that must be seen.
    typedef struct {
        logic        i_rdy, d_rdy, halt, drf, ddm, drd, btk;
        logic [31:0] rdata, btgt;
        logic        e_ireq, e_dreq, e_dwe, e_rfw, e_ret, e_halted;
        logic [31:0] e_pc, e_instr;
        logic [63:0] e_cyc, e_ins;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [63:0] m_cyc;
    logic [63:0] m_ret;
    int          total = 0;
    int          bad = 0;
    int          rec_idx = 0;
    int          first_ret = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Don't-care inputs are randomized so gating of ignored inputs is exercised.
    function automatic rec_t base();
        rec_t r;
        r.i_rdy = 1'($urandom); r.d_rdy = 1'($urandom); r.halt = 1'($urandom);
        r.drf = 1'($urandom); r.ddm = 1'($urandom); r.drd = 1'($urandom); r.btk = 1'($urandom);
        r.rdata = $urandom; r.btgt = $urandom;
        r.e_ireq = 1'b0; r.e_dreq = 1'b0; r.e_dwe = 1'b0; r.e_rfw = 1'b0; r.e_ret = 1'b0;
        r.e_halted = 1'b0;
        r.e_pc = m_pc; r.e_instr = m_instr; r.e_cyc = m_cyc; r.e_ins = m_ret;
        return r;
    endfunction

    function automatic void push(input rec_t r);
        q.push_back(r);
        m_cyc = m_cyc + 64'd1;
        if (r.e_ret) m_ret = m_ret + 64'd1;
    endfunction

    function automatic void push_idle(input logic h);
        rec_t r = base();
        r.halt = h;
        r.e_halted = 1'b1;
        push(r);
    endfunction

    // kind: 0 ALU/branch, 1 load, 2 store; wi/wd = fetch/data wait cycles.
    function automatic void push_instr(input int kind, input int wi, input int wd, input logic rf,
                                       input logic tk, input logic [31:0] tgt, input logic hlt,
                                       input int idle);
        rec_t        r;
        logic [31:0] word = $urandom;
        logic        drd = (kind == 1);
        logic        ddm = (kind == 2);
        for (int i = 0; i <= wi; i++) begin
            r = base();
            r.e_ireq = 1'b1;
            r.i_rdy = (i == wi);
            if (i == wi) r.rdata = word;
            push(r);
        end
        m_instr = word;
        r = base();
        push(r);
        r = base();
        r.drf = rf; r.ddm = ddm; r.drd = drd;
        push(r);
        if (drd || ddm) begin
            for (int i = 0; i <= wd; i++) begin
                r = base();
                r.drf = rf; r.ddm = ddm; r.drd = drd;
                r.e_dreq = 1'b1; r.e_dwe = ddm; r.d_rdy = (i == wd);
                push(r);
            end
        end
        r = base();
        r.drf = rf; r.ddm = ddm; r.drd = drd;
        r.btk = tk; r.btgt = tgt; r.halt = hlt;
        r.e_rfw = rf; r.e_ret = 1'b1;
        push(r);
        m_pc = tk ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
        if (hlt) begin
            for (int i = 0; i < idle; i++) push_idle(1'b1);
            push_idle(1'b0);
        end
    endfunction

    task automatic run_n(input int n);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r = q.pop_front();
            @(negedge clk);
            imem_ready = r.i_rdy; imem_rdata = r.rdata; dmem_ready = r.d_rdy; halt_req = r.halt;
            dec_rf_wen = r.drf; dec_dm_wen = r.ddm; dec_mem_rd = r.drd;
            branch_taken = r.btk; branch_target = r.btgt;
            #1;
            chk("imem_req", {63'd0, imem_req}, {63'd0, r.e_ireq});
            chk("imem_addr", {32'd0, imem_addr}, {32'd0, r.e_pc});
            chk("pc", {32'd0, pc}, {32'd0, r.e_pc});
            chk("instr", {32'd0, instr}, {32'd0, r.e_instr});
            chk("dmem_req", {63'd0, dmem_req}, {63'd0, r.e_dreq});
            chk("dmem_we", {63'd0, dmem_we}, {63'd0, r.e_dwe});
            chk("rf_wen", {63'd0, rf_wen}, {63'd0, r.e_rfw});
            chk("retire", {63'd0, retire}, {63'd0, r.e_ret});
            chk("halted", {63'd0, halted}, {63'd0, r.e_halted});
`ifdef SEQ_PERF_CNT_EN
            chk("cycle_cnt", cycle_cnt, r.e_cyc);
            chk("instret_cnt", instret_cnt, r.e_ins);
`else
            chk("cycle_cnt", cycle_cnt, 64'd0);
            chk("instret_cnt", instret_cnt, 64'd0);
`endif
            if (r.e_ret && first_ret < 0) first_ret = rec_idx;
            rec_idx++;
        end
    endtask

    task automatic check_reset_state();
        chk("rst_halted", {63'd0, halted}, 64'd1);
        chk("rst_pc", {32'd0, pc}, {32'd0, RPC});
        chk("rst_instr", {32'd0, instr}, {32'd0, NOP});
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
        chk("rst_retire", {63'd0, retire}, 64'd0);
        chk("rst_cycle_cnt", cycle_cnt, 64'd0);
        chk("rst_instret_cnt", instret_cnt, 64'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = RPC; m_instr = NOP; m_cyc = '0; m_ret = '0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1 check_reset_state();

        @(posedge clk);
        #2 rst_n = 1'b1;
        push_idle(1'b0);
        push_instr(0, 0, 0, 1'b1, 1'b0, 32'd0, 1'b0, 0);
        run_n(q.size());
        chk("first_retire_cycle", 64'(first_ret), 64'd4);
        @(posedge clk);
        #1 chk("pc_after_addi", {32'd0, pc}, 64'h104);

        push_instr(0, 3, 0, 1'b1, 1'b0, 32'd0, 1'b0, 0);
        push_instr(1, 0, 2, 1'b1, 1'b0, 32'd0, 1'b0, 0);
        push_instr(2, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 0);
        push_instr(0, 0, 0, 1'b0, 1'b1, 32'h203, 1'b0, 0);
        run_n(q.size());
        @(posedge clk);
        #1 chk("pc_taken_branch", {32'd0, pc}, 64'h200);

        push_instr(0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
        push_instr(0, 1, 0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 0);
        run_n(q.size());
        @(posedge clk);
        #1 chk("pc_wrap", {32'd0, pc}, 64'h0);

        push_instr(0, 0, 0, 1'b1, 1'b0, 32'd0, 1'b1, 3);
        push_instr(1, 1, 1, 1'b1, 1'b0, 32'd0, 1'b0, 0);
        run_n(q.size());

        for (int i = 0; i < 150; i++) begin
            push_instr($urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                       ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                       1'($urandom), 1'($urandom), $urandom,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 3));
            run_n(q.size());
        end

        // Reset arrives while a load is stalled in MEM.
        push_instr(1, 0, 6, 1'b1, 1'b0, 32'd0, 1'b0, 0);
        run_n(5);
        chk("pre_rst_dmem_req", {63'd0, dmem_req}, 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        push_idle(1'b0);
        push_instr(2, 0, 1, 1'b0, 1'b0, 32'd0, 1'b0, 0);
        push_instr(0, 0, 0, 1'b1, 1'b0, 32'd0, 1'b0, 0);
        run_n(q.size());
        @(posedge clk);
        #1 chk("pc_after_rst_run", {32'd0, pc}, 64'h108);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle sequencer for the single-issue RV32I core. It owns the PC and instruction register and fetches over a req/ready handshake. It steps every instruction through FETCH, DECODE, EXECUTE, optional MEM, and WB. It gates the decoder's register-file and data-memory write enables so each fires exactly once per instruction. It sits between instruction/data memory and the combinational decoder/ALU datapath.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: core clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, equals `pc`.
- `imem_ready` in 1: fetch completes on a rising edge where `imem_req && imem_ready`.
- `imem_rdata` in 32: instruction word, valid with `imem_ready`.
- `instr` out 32: registered instruction, drives the decoder.
- `pc` out 32: current instruction address.
- `dec_rf_wen` in 1: decoder register-write request.
- `dec_dm_wen` in 1: decoder store.
- `dec_mem_rd` in 1: decoder load.
- `branch_taken` in 1: branch/jump resolved taken; sampled in WB.
- `branch_target` in 32: next PC when taken.
- `rf_wen` out 1: gated register-file write enable.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data write.
- `dmem_ready` in 1: data access completes on a rising edge where `dmem_req && dmem_ready`.
- `halt_req` in 1: stop after the current instruction.
- `halted` out 1: sequencer is in IDLE.
- `retire` out 1: one-cycle pulse per completed instruction.
- `cycle_cnt` out 64: see Configuration.
- `instret_cnt` out 64: see Configuration.

## Operation
- States are IDLE, FETCH, DECODE, EXEC, MEM, WB, encoded as a 3-bit enum.
- Outputs are Moore (decoded from state); `rf_wen` and `dmem_we` also AND in the decoder inputs.
- IDLE: `halted=1`. Moves to FETCH when `halt_req=0`.
- FETCH:
  - `imem_req=1`; `imem_addr=pc` is held stable until accepted.
  - On accept: `instr<=imem_rdata`, go to DECODE.
  - Otherwise stay in FETCH indefinitely; there is no timeout.
- DECODE: one cycle; decoder and register-file outputs settle. Go to EXEC.
- EXEC: one cycle. Go to MEM if `dec_mem_rd|dec_dm_wen`, else go to WB.
- MEM:
  - `dmem_req=1` and `dmem_we=dec_dm_wen`, held until `dmem_ready`, then go to WB.
  - `dmem_we` is 0 in every other state.
- WB:
  - `rf_wen=dec_rf_wen` and `retire=1` for exactly this cycle.
  - `pc <= branch_taken ? {branch_target[31:2],2'b00} : pc+32'd4`. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Next state is IDLE if `halt_req=1`, else FETCH.
- `halt_req` is only sampled in WB and IDLE. Asserting it mid-instruction never aborts that instruction.
- A load or store is never issued twice. `rf_wen` is never high outside WB.
- `instr` holds its value from DECODE through WB.

## Timing
- Reset asserted, asynchronously: state=IDLE, `pc=RESET_PC`, `instr=32'h0000_0013` (NOP), all request/enable/pulse outputs 0, counters 0.
- With reset asserted, `halted=1`, since that is decoded from IDLE.
- Any outstanding memory request is abandoned immediately on reset; the memories must tolerate `req` dropping.
- First FETCH occurs one cycle after `rst_n` deasserts, provided `halt_req=0`.
- Zero-wait memories:
  - ALU/branch instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
- Each cycle of `imem_ready` or `dmem_ready` low adds exactly one cycle.
- Back-to-back instructions: WB is followed directly by FETCH, so there is no idle bubble.
- `ready` asserted without a `req` is ignored.

## Configuration
- The performance counters are compiled in by `SEQ_PERF_CNT_EN`.
- Defined:
  - `cycle_cnt` increments every cycle after reset, including IDLE and stalls.
  - `instret_cnt` increments on every `retire`.
  - Both are 64-bit and wrap to 0.
- Undefined: both outputs are tied to 64'd0 and no counter flops are synthesized.

## Test plan
- **Reset and first fetch.** `RESET_PC=32'h100`; release `rst_n` with `imem_ready=1` and an ADDI.
  - `imem_addr=32'h100` on cycle 1; `retire` on cycle 4; `pc=32'h104` after; `rf_wen` high exactly 1 cycle.
- **Fetch wait states.** Hold `imem_ready=0` for 3 cycles.
  - `imem_req` and `imem_addr` stay stable; the instruction retires 3 cycles later (7 total).
- **Load with 2 wait cycles.** `dec_mem_rd=1`, `dmem_ready` low for 2 cycles.
  - `dmem_req` high 3 cycles with `dmem_we=0`; `rf_wen` pulses once in WB.
- **Store.** `dec_dm_wen=1`, `dec_rf_wen=0`.
  - `dmem_we=1` only in MEM; `rf_wen` stays 0; retire at cycle 5.
- **Taken branch and PC wrap.**
  - Taken branch with `branch_target=32'h203` gives `pc=32'h200`.
  - Not-taken branch at `pc=32'hFFFF_FFFC` gives `pc=0`.
- **Halt and mid-operation reset.**
  - `halt_req` asserted during EXEC: the instruction retires, then `halted=1` and there is no fetch until `halt_req` drops.
  - `rst_n` low during MEM: `dmem_req` drops immediately and `pc` returns to `RESET_PC`.
  - With `SEQ_PERF_CNT_EN`, `instret_cnt` equals the `retire` count.
